// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled, LSB-first, one-byte holding buffer with a
// sticky ready flag and a read-to-clear ren/data/ready register interface.
module uart_rx #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       ren,
  output logic [7:0] data,
  output logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic [2:0] dbg_state,
  output logic       dbg_tick
);

  localparam int TICK_DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW       = $clog2(OVERSAMPLE);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SMP_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SMP_MID   = SW'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BRK   = 3'd4
  } state_t;

  logic          rx_meta;
  logic          rx_sync;
  logic [TW-1:0] tick_cnt;
  logic          tick;

  state_t        state_q;
  state_t        state_d;
  logic [SW-1:0] smp_q;
  logic [SW-1:0] smp_d;
  logic [2:0]    bit_q;
  logic [2:0]    bit_d;
  logic [7:0]    shift_q;
  logic [7:0]    shift_d;
  logic          load_now;
  logic          ferr_now;

  // Two-flop synchronizer; flops come out of reset at the idle line level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      smp_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Each state counts ticks from zero on entry; the sample point is the last
  // tick of the interval (half a bit for START, a full bit otherwise).
  always_comb begin
    state_d  = state_q;
    smp_d    = smp_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    load_now = 1'b0;
    ferr_now = 1'b0;
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_sync) begin
            state_d = S_START;
            smp_d   = '0;
          end
        end
        S_START: begin
          if (smp_q == SMP_MID) begin
            smp_d   = '0;
            bit_d   = '0;
            state_d = rx_sync ? S_IDLE : S_DATA;
          end else begin
            smp_d = smp_q + 1'b1;
          end
        end
        S_DATA: begin
          if (smp_q == SMP_LAST) begin
            smp_d   = '0;
            shift_d = {rx_sync, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = S_STOP;
            end
          end else begin
            smp_d = smp_q + 1'b1;
          end
        end
        S_STOP: begin
          if (smp_q == SMP_LAST) begin
            smp_d = '0;
            if (rx_sync) begin
              load_now = 1'b1;
              state_d  = S_IDLE;
            end else begin
              ferr_now = 1'b1;
              state_d  = S_BRK;
            end
          end else begin
            smp_d = smp_q + 1'b1;
          end
        end
        S_BRK: begin
          if (rx_sync) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Handshake: ready=1 means data holds an unconsumed byte. A ren pulse while
  // ready=1 consumes it (ready and overrun drop next clk, data is kept); ren
  // while ready=0 is ignored. A new byte always loads; if it lands on an
  // unconsumed byte without ren in the same clk, overrun sets and stays set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data      <= '0;
      ready     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_now;
      if (load_now) begin
        data    <= shift_q;
        ready   <= 1'b1;
        overrun <= ren ? 1'b0 : (overrun | ready);
      end else if (ren && ready) begin
        ready   <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

  assign dbg_state = state_q;
  assign dbg_tick  = tick;

endmodule
